// File: rtl/ubcska_pkg.sv
// Shared helpers for the pipelined carry-skip adder/subtractor.
//   nstg       : number of pipeline stages for a given width and stage slice width
//   slice_lo/hi: bit range handled by stage k (the last slice may be narrower)
//   blk_count  : number of skip blocks needed to cover a slice
//   params_ok  : legality of the top-level parameter set
package ubcska_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MIN_BLK   = 1;

    function automatic int nstg(input int width, input int sw);
        return (width + sw - 1) / sw;
    endfunction

    function automatic int slice_lo(input int k, input int sw);
        return k * sw;
    endfunction

    function automatic int slice_hi(input int k, input int sw, input int width);
        int hi;
        hi = (k + 1) * sw - 1;
        return (hi > width - 1) ? width - 1 : hi;
    endfunction

    function automatic int blk_count(input int width, input int blk);
        return (width + blk - 1) / blk;
    endfunction

    function automatic bit params_ok(input int width, input int blk, input int bps);
        return (width >= MIN_WIDTH) && (blk >= MIN_BLK) && (blk <= width) && (bps >= 1);
    endfunction

endpackage

// File: rtl/ubcskb_blk.sv
// One carry-skip block: ripple carry inside the block, plus a skip path that
// forwards the block carry-in to the carry-out when every bit propagates.
// Ports:
//   x, y   : W-bit operand slices (y already inverted for subtraction)
//   ci     : block carry-in
//   s      : W-bit sum slice
//   co     : block carry-out (ripple OR skip)
//   p_all  : all bits of the block propagate
module ubcskb_blk #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         p_all
);

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;

    assign p     = x ^ y;
    assign g     = x & y;
    assign p_all = &p;

    always_comb begin
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s  = p ^ c[W-1:0];
    // The skip term is logically implied by the ripple term; it is kept as a
    // separate fast path so the carry does not have to walk the block.
    assign co = c[W] | (p_all & ci);

endmodule

// File: rtl/ubcska_pipe.sv
// Pipelined carry-skip adder/subtractor with valid/ready flow control.
// Each stage adds one SW-bit slice using BLKS_PER_STG skip blocks, then
// registers the finished low sum bits, the slice carry-out and the operand
// bits still to be processed. Operand Y is inverted ahead of stage 0 for sub.
// Handshake: a beat moves on a rising edge when valid and ready are both high;
// a stage is ready when it is empty or the stage after it is ready, so stalled
// stages hold their data and bubbles collapse.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid, in_ready  : input handshake
//   x, y, cin, sub      : operands, carry-in, subtract select
//   out_valid, out_ready: output handshake
//   sum, cout, ovf      : result, carry out of MSB, signed overflow
module ubcska_pipe
    import ubcska_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int BLK          = 4,
    parameter int BLKS_PER_STG = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW   = BLK * BLKS_PER_STG;
    localparam int NSTG = nstg(WIDTH, SW);

    if (!params_ok(WIDTH, BLK, BLKS_PER_STG)) begin : g_param_check
        $error("ubcska_pipe: illegal WIDTH/BLK/BLKS_PER_STG");
    end

    logic [WIDTH-1:0] y_eff;
    logic             cin0;

    // Subtraction is X + ~Y + 1; cin is ORed into that forced carry.
    assign y_eff = y ^ {WIDTH{sub}};
    assign cin0  = sub | cin;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO   = slice_lo(k, SW);
        localparam int HI   = slice_hi(k, SW, WIDTH);
        localparam int SWK  = HI - LO + 1;
        localparam int NB   = blk_count(SWK, BLK);
        localparam bit LAST = (k == NSTG - 1);

        // a_x/a_y hold operand bits LO and upward (what is left to add).
        logic [WIDTH-LO-1:0] a_x;
        logic [WIDTH-LO-1:0] a_y;
        logic                a_c;
        logic                a_v;
        logic                rdy;
        logic                rdy_nxt;
        logic [SWK-1:0]      s_sl;
        logic [NB-1:0]       pa;
        logic                c_nxt;
        logic [HI:0]         n_s;
        logic                v;
        logic                c;
        logic [HI:0]         sq;

        if (k == 0) begin : g_src
            assign a_x = x;
            assign a_y = y_eff;
            assign a_c = cin0;
            assign a_v = in_valid;
            assign n_s = s_sl;
        end else begin : g_src
            assign a_x = g_stg[k-1].g_rem.xq;
            assign a_y = g_stg[k-1].g_rem.yq;
            assign a_c = g_stg[k-1].c;
            assign a_v = g_stg[k-1].v;
            assign n_s = {s_sl, g_stg[k-1].sq};
        end

        if (LAST) begin : g_nxt
            assign rdy_nxt = out_ready;
        end else begin : g_nxt
            assign rdy_nxt = g_stg[k+1].rdy;
        end

        assign rdy = !v | rdy_nxt;

        for (genvar j = 0; j < NB; j++) begin : g_blk
            localparam int BOFF = j * BLK;
            localparam int BW   = (SWK - BOFF < BLK) ? (SWK - BOFF) : BLK;

            logic          ci;
            logic          co;
            logic [BW-1:0] s;

            if (j == 0) begin : g_ci
                assign ci = a_c;
            end else begin : g_ci
                assign ci = g_blk[j-1].co;
            end

            ubcskb_blk #(.W(BW)) u_blk (
                .x     (a_x[BOFF +: BW]),
                .y     (a_y[BOFF +: BW]),
                .ci    (ci),
                .s     (s),
                .co    (co),
                .p_all (pa[j])
            );

            assign s_sl[BOFF +: BW] = s;
        end

        // Stage-level skip: if every block propagates, the slice carry-in
        // is the slice carry-out.
        assign c_nxt = g_blk[NB-1].co | ((&pa) & a_c);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v  <= 1'b0;
                c  <= 1'b0;
                sq <= '0;
            end else if (rdy) begin
                v <= a_v;
                if (a_v) begin
                    c  <= c_nxt;
                    sq <= n_s;
                end
            end
        end

        if (!LAST) begin : g_rem
            logic [WIDTH-HI-2:0] xq;
            logic [WIDTH-HI-2:0] yq;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    xq <= '0;
                    yq <= '0;
                end else if (rdy && a_v) begin
                    xq <= a_x[WIDTH-LO-1:SWK];
                    yq <= a_y[WIDTH-LO-1:SWK];
                end
            end
        end else begin : g_msb
            // Carry into the MSB, recovered from s = p ^ c at the top bit.
            logic cm;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cm <= 1'b0;
                end else if (rdy && a_v) begin
                    cm <= s_sl[SWK-1] ^ a_x[SWK-1] ^ a_y[SWK-1];
                end
            end
        end
    end

    assign in_ready  = g_stg[0].rdy;
    assign out_valid = g_stg[NSTG-1].v;
    assign sum       = g_stg[NSTG-1].sq;
    assign cout      = g_stg[NSTG-1].c;
    assign ovf       = g_stg[NSTG-1].g_msb.cm ^ g_stg[NSTG-1].c;

endmodule
